serial_wb_framer: RTL and testbench

//  Host-side encoder for the serial Wishbone bridge byte protocol: turns one transaction request
//  (read/write, 32-bit address, 16-bit byte count) plus a write-data byte stream into the framed

---
 rtl/serial_wb_pkg.sv | 19 +
 rtl/serial_wb_framer_axis_byte_reg.sv | 40 ++++
 rtl/serial_wb_framer.sv | 155 +++++++++++++++
 tb/tb_serial_wb_framer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_wb_pkg.sv
// Shared definitions for the serial Wishbone bridge byte protocol.
// The bridge decoder uses the same definitions.
package serial_wb_pkg;

  localparam logic [7:0] DEF_CMD_WR   = 8'hA2;
  localparam logic [7:0] DEF_CMD_RD   = 8'hA1;
  localparam logic [7:0] DEF_EOF_BYTE = 8'h00;
  localparam int         HDR_LEN      = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_CNT,
    ST_DATA,
    ST_EOF
  } state_t;

endpackage

// File: rtl/serial_wb_framer_axis_byte_reg.sv
// Registered 8-bit AXIS output stage with tlast.
// A byte is loaded when the stage is empty or is draining, and is held while the sink stalls.
module axis_byte_reg (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_can_load
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/serial_wb_framer.sv
// Host-side framer: request + payload stream -> CMD, ADDR[3:0], CNT[1:0], DATA*, EOF bytes.
// Every state except ST_DATA names the header byte held in the output register.
module serial_wb_framer
  import serial_wb_pkg::*;
#(
  parameter logic [7:0] CMD_WR   = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD   = DEF_CMD_RD,
  parameter logic [7:0] EOF_BYTE = DEF_EOF_BYTE
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [15:0] i_req_count,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        o_busy
);

  state_t      r_state, w_nxt_state;
  logic [1:0]  r_idx, w_nxt_idx, w_idx_m1;
  logic [15:0] r_rem;
  logic [31:0] r_addr;
  logic [15:0] r_cnt;
  logic        r_write;

  logic        w_accept, w_out_hs, w_can_load, w_has_data;
  logic        w_load, w_ld_last, w_s_ready, w_s_hs;
  logic [7:0]  w_ld_data;

  assign o_req_ready   = (r_state == ST_IDLE) && i_rst_n;
  assign w_accept      = i_req_valid && o_req_ready;
  assign w_out_hs      = m_axis_tvalid && m_axis_tready;
  assign w_has_data    = r_write && (r_cnt != 16'd0);
  assign w_idx_m1      = r_idx - 2'd1;
  assign s_axis_tready = w_s_ready;
  assign w_s_hs        = w_s_ready && s_axis_tvalid;
  assign o_busy        = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_rem   <= 16'd0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      if (w_accept)
        r_rem <= i_req_count;
      else if (w_s_hs)
        r_rem <= r_rem - 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_addr  <= i_req_addr;
      r_cnt   <= i_req_count;
      r_write <= i_req_write;
    end
  end

  // DATA is entered as CNT0 is loaded, so the first payload byte can follow CNT0 without a bubble.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_load      = 1'b0;
    w_ld_data   = 8'h00;
    w_ld_last   = 1'b0;
    w_s_ready   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_ld_data   = i_req_write ? CMD_WR : CMD_RD;
          w_nxt_state = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_out_hs) begin
          w_load      = 1'b1;
          w_ld_data   = r_addr[31:24];
          w_nxt_idx   = 2'd3;
          w_nxt_state = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_out_hs) begin
          w_load = 1'b1;
          if (r_idx == 2'd0) begin
            w_ld_data   = r_cnt[15:8];
            w_nxt_idx   = 2'd1;
            w_nxt_state = ST_CNT;
          end else begin
            w_ld_data = r_addr[{w_idx_m1, 3'b000} +: 8];
            w_nxt_idx = w_idx_m1;
          end
        end
      end
      ST_CNT: begin
        if (w_out_hs) begin
          w_load = 1'b1;
          if (r_idx == 2'd1) begin
            w_ld_data = r_cnt[7:0];
            w_nxt_idx = 2'd0;
            if (w_has_data)
              w_nxt_state = ST_DATA;
          end else begin
            w_ld_data   = EOF_BYTE;
            w_ld_last   = 1'b1;
            w_nxt_state = ST_EOF;
          end
        end
      end
      ST_DATA: begin
        w_s_ready = w_can_load && (r_rem != 16'd0);
        if (w_s_hs) begin
          w_load    = 1'b1;
          w_ld_data = s_axis_tdata;
        end else if ((r_rem == 16'd0) && w_can_load) begin
          w_load      = 1'b1;
          w_ld_data   = EOF_BYTE;
          w_ld_last   = 1'b1;
          w_nxt_state = ST_EOF;
        end
      end
      ST_EOF: begin
        if (w_out_hs)
          w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  axis_byte_reg u_out (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_data     (w_ld_data),
    .i_last     (w_ld_last),
    .i_ready    (m_axis_tready),
    .o_valid    (m_axis_tvalid),
    .o_data     (m_axis_tdata),
    .o_last     (m_axis_tlast),
    .o_can_load (w_can_load)
  );

endmodule

// File: tb/tb_serial_wb_framer.sv
// Directed bench for serial_wb_framer: framing, stalls, zero-count, mid-frame reset, back-to-back.
module tb_serial_wb_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [15:0] req_count;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] pay[$];
  logic [7:0] rxq[$];
  logic       lastq[$];
  int         hscyc[$];
  logic [7:0] expq[$];
  bit         saw_sready;
  int         stall_err;

  always #5 clk = ~clk;

  serial_wb_framer dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_write   (req_write),
    .i_req_addr    (req_addr),
    .i_req_count   (req_count),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .o_busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request, then runs cycles until n_frames EOF beats or abort_after beats are seen.
  task automatic run_frame(input bit wr, input logic [31:0] addr, input logic [15:0] cnt,
                           input bit toggle, input int abort_after, input int n_frames);
    int   pi, acc, nlast;
    bit   done, prev_stall;
    logic [7:0] prev_data;
    rxq.delete(); lastq.delete(); hscyc.delete();
    saw_sready = 1'b0; stall_err = 0;
    pi = 0; acc = 1; nlast = 0; done = 1'b0; prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_count = cnt;
    m_tready = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      req_valid = (acc < n_frames);
      m_tready  = toggle ? (c % 2 == 0) : 1'b1;
      s_tvalid  = (pi < pay.size());
      s_tdata   = s_tvalid ? pay[pi] : 8'h00;
      #1;
      if (prev_stall && !(m_tvalid && m_tdata === prev_data)) stall_err++;
      if (s_tready) saw_sready = 1'b1;
      if (s_tready && s_tvalid) pi++;
      if (req_valid && req_ready) acc++;
      if (m_tvalid && m_tready) begin
        rxq.push_back(m_tdata);
        lastq.push_back(m_tlast);
        hscyc.push_back(c);
        if (m_tlast) nlast++;
        if (nlast == n_frames || rxq.size() == abort_after) done = 1'b1;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
    end
    chk("frame_done", done, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; s_tvalid = 1'b0;
  endtask

  task automatic check_bytes(input string tag, input int frame_len);
    chk({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i), rxq[i], expq[i]);
      chk($sformatf("%s_last%0d", tag, i), lastq[i], ((i + 1) % frame_len == 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_count = '0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    #1;
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tdata", m_tdata, 8'h00);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("release_req_ready", req_ready, 1'b1);

    // 1: write, 4 payload bytes, continuous tready
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(1'b1, 32'h0000_0000, 16'd4, 1'b0, 0, 1);
    expq = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    check_bytes("wr4", 12);
    if (hscyc.size() == 12) begin
      chk("wr4_cmd_latency", hscyc[0], 0);
      chk("wr4_consecutive", hscyc[11] - hscyc[0], 11);
    end
    chk("wr4_idle_after", busy, 1'b0);

    // 2: read, payload offered but never taken
    pay = '{8'h55, 8'h66};
    run_frame(1'b0, 32'h1234_5678, 16'h0010, 1'b0, 0, 1);
    expq = '{8'hA1, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h10, 8'h00};
    check_bytes("rd", 8);
    chk("rd_s_tready_seen", saw_sready, 1'b0);

    // 3: write with output stalls every other cycle
    pay = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(1'b1, 32'hA0B1_C2D3, 16'd4, 1'b1, 0, 1);
    expq = '{8'hA2, 8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'h00, 8'h04,
             8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    check_bytes("stall", 12);
    chk("stall_hold_errors", stall_err, 0);

    // 4: write with count=0
    pay = '{8'h77};
    run_frame(1'b1, 32'h0000_0010, 16'd0, 1'b0, 0, 1);
    expq = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    check_bytes("wr0", 8);
    chk("wr0_s_tready_seen", saw_sready, 1'b0);

    // 5: reset right after the ADDR1 handshake, then a fresh frame
    pay = '{8'h01, 8'h02};
    run_frame(1'b1, 32'hCAFE_F00D, 16'd2, 1'b0, 4, 1);
    expq = '{8'hA2, 8'hCA, 8'hFE, 8'hF0};
    check_bytes("pre_abort", 100);
    chk("pre_abort_busy", busy, 1'b1);
    chk("pre_abort_tvalid", m_tvalid, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_tvalid", m_tvalid, 1'b0);
    chk("abort_tdata", m_tdata, 8'h00);
    chk("abort_req_ready", req_ready, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("abort_release_ready", req_ready, 1'b1);
    chk("abort_release_tvalid", m_tvalid, 1'b0);
    pay = '{8'h5A};
    run_frame(1'b1, 32'h0000_0001, 16'd1, 1'b0, 0, 1);
    expq = '{8'hA2, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h5A, 8'h00};
    check_bytes("post_abort", 9);

    // 6: request held valid across two read frames
    pay.delete();
    run_frame(1'b0, 32'h0000_0100, 16'h0002, 1'b0, 0, 2);
    expq = '{8'hA1, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
             8'hA1, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00};
    check_bytes("b2b", 8);
    if (hscyc.size() == 16)
      chk("b2b_gap", hscyc[8] - hscyc[7], 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
